// File: rtl/edge_evt_pkg.sv
// Shared types and helpers for the edge-event arbiter.
//   edge_mode_t : per-channel edge selection (rise / fall / both / off)
//   rr_pick     : round-robin grant index, searching from last+1 modulo n_ch
package edge_evt_pkg;

    localparam int unsigned MAX_CH = 16;
    localparam int unsigned IDX_W  = 4;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_OFF  = 2'b11
    } edge_mode_t;

    // Walk offsets from farthest to nearest so the nearest set bit after
    // 'last' is the one left in 'pick'. Returns 'last' when nothing is set.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [MAX_CH-1:0] pend,
        input logic [IDX_W-1:0]  last,
        input int unsigned       n_ch
    );
        logic [IDX_W-1:0] pick;
        int unsigned      idx;
        pick = last;
        for (int unsigned i = MAX_CH; i > 0; i--) begin
            if (i <= n_ch) begin
                idx = (32'(last) + i) % n_ch;
                if (pend[IDX_W'(idx)]) begin
                    pick = IDX_W'(idx);
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/edge_det_cfg.sv
// Single-channel configurable edge detector.
//   clk, reset : clock, async active-high reset
//   armed      : detection enable (low for the first cycle after reset)
//   sig        : monitored level, already synchronous to clk
//   mode       : edge selection
//   det        : combinational, a selected edge is seen this cycle
//   is_rise    : combinational, the current edge is a rising one
module edge_det_cfg
    import edge_evt_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       armed,
    input  logic       sig,
    input  edge_mode_t mode,
    output logic       det,
    output logic       is_rise
);

    logic sig_q;
    logic sig_d;
    logic rise;
    logic fall;

    // Previous-sample register; loads even while disarmed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_d;
        end
    end

    always_comb begin
        sig_d   = sig;
        rise    = sig & ~sig_q;
        fall    = ~sig & sig_q;
        is_rise = rise;
        det     = 1'b0;
        unique case (mode)
            EDGE_RISE: det = rise;
            EDGE_FALL: det = fall;
            EDGE_BOTH: det = rise | fall;
            EDGE_OFF:  det = 1'b0;
            default:   det = 1'b0;
        endcase
        det = det & armed;
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event scheduler: per-channel sticky pending flags,
// round-robin serialisation onto a single valid/ready output slot.
//   clk, reset : clock, async active-high reset
//   i_sig      : N_CH monitored levels
//   i_mode     : 2 bits per channel, see edge_mode_t
//   o_valid/o_ch/o_rise/i_ready : event output handshake
//   o_ovf      : sticky per-channel overflow flags
//   i_ovf_clr  : synchronous clear of all overflow flags
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter int unsigned N_CH = 4,
    localparam int unsigned CH_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   i_sig,
    input  logic [2*N_CH-1:0] i_mode,
    output logic              o_valid,
    output logic [CH_W-1:0]   o_ch,
    output logic              o_rise,
    input  logic              i_ready,
    output logic [N_CH-1:0]   o_ovf,
    input  logic              i_ovf_clr
);

    logic            armed_q, armed_d;
    logic [N_CH-1:0] pend_q,  pend_d;
    logic [N_CH-1:0] ptype_q, ptype_d;
    logic [N_CH-1:0] ovf_q,   ovf_d;
    logic [CH_W-1:0] last_q,  last_d;
    logic            valid_q, valid_d;
    logic [CH_W-1:0] ch_q,    ch_d;
    logic            rise_q,  rise_d;

    logic [N_CH-1:0] det;
    logic [N_CH-1:0] is_rise;
    logic            slot_free;
    logic            grant;
    logic [CH_W-1:0] gnt_ch;

    // One detector per channel.
    for (genvar c = 0; c < N_CH; c++) begin : g_det
        edge_det_cfg u_det (
            .clk     (clk),
            .reset   (reset),
            .armed   (armed_q),
            .sig     (i_sig[c]),
            .mode    (edge_mode_t'(i_mode[2*c +: 2])),
            .det     (det[c]),
            .is_rise (is_rise[c])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed_q <= 1'b0;
            pend_q  <= '0;
            ptype_q <= '0;
            ovf_q   <= '0;
            last_q  <= CH_W'(N_CH - 1);
            valid_q <= 1'b0;
            ch_q    <= '0;
            rise_q  <= 1'b0;
        end else begin
            armed_q <= armed_d;
            pend_q  <= pend_d;
            ptype_q <= ptype_d;
            ovf_q   <= ovf_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            ch_q    <= ch_d;
            rise_q  <= rise_d;
        end
    end

    always_comb begin
        armed_d = 1'b1;
        pend_d  = pend_q;
        ptype_d = ptype_q;
        ovf_d   = i_ovf_clr ? '0 : ovf_q;
        last_d  = last_q;
        valid_d = valid_q;
        ch_d    = ch_q;
        rise_d  = rise_q;

        slot_free = ~valid_q | i_ready;
        grant     = slot_free & (|pend_q);
        gnt_ch    = CH_W'(rr_pick(MAX_CH'(pend_q), IDX_W'(last_q), N_CH));

        // Output slot: refill from the arbiter or drain.
        if (grant) begin
            valid_d        = 1'b1;
            ch_d           = gnt_ch;
            rise_d         = ptype_q[gnt_ch];
            last_d         = gnt_ch;
            pend_d[gnt_ch] = 1'b0;
        end else if (slot_free) begin
            valid_d = 1'b0;
        end

        // New events: a channel whose flag is leaving this cycle re-arms
        // with the new type; otherwise a second event is dropped as overflow.
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (det[c]) begin
                if (pend_q[c] && !(grant && (gnt_ch == CH_W'(c)))) begin
                    ovf_d[c] = 1'b1;
                end else begin
                    pend_d[c]  = 1'b1;
                    ptype_d[c] = is_rise[c];
                end
            end
        end
    end

    assign o_valid = valid_q;
    assign o_ch    = ch_q;
    assign o_rise  = rise_q;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter with an expected-event scoreboard.
module tb_edge_event_arbiter;

    localparam int unsigned N_CH = 4;
    localparam int unsigned CH_W = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [N_CH-1:0]   i_sig;
    logic [2*N_CH-1:0] i_mode;
    logic              o_valid;
    logic [CH_W-1:0]   o_ch;
    logic              o_rise;
    logic              i_ready;
    logic [N_CH-1:0]   o_ovf;
    logic              i_ovf_clr;

    typedef struct {
        int ch;
        int rise;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    edge_event_arbiter #(.N_CH(N_CH)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_sig     (i_sig),
        .i_mode    (i_mode),
        .o_valid   (o_valid),
        .o_ch      (o_ch),
        .o_rise    (o_rise),
        .i_ready   (i_ready),
        .o_ovf     (o_ovf),
        .i_ovf_clr (i_ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int ch, input int rise);
        exp_t e;
        e.ch   = ch;
        e.rise = rise;
        sb.push_back(e);
    endtask

    // Compare the presented event against the oldest expected one.
    task automatic pop_check(input string tag);
        exp_t e;
        chk({tag, "_valid"}, int'(o_valid), 1);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_ch"}, int'(o_ch), e.ch);
            chk({tag, "_rise"}, int'(o_rise), e.rise);
        end
    endtask

    task automatic idle(input string tag);
        chk(tag, int'(o_valid), 0);
    endtask

    task automatic set_mode(input int c, input logic [1:0] m);
        i_mode[2*c +: 2] = m;
    endtask

    initial begin
        reset     = 1'b1;
        i_sig     = 4'b0101;
        i_mode    = '0;
        i_ready   = 1'b1;
        i_ovf_clr = 1'b0;

        // Reset state, then release with lines 0 and 2 already high.
        tick();
        tick();
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_ch", int'(o_ch), 0);
        chk("rst_rise", int'(o_rise), 0);
        chk("rst_ovf", int'(o_ovf), 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            idle("release_idle");
        end
        chk("release_ovf", int'(o_ovf), 0);

        // Single rise on ch2: valid one cycle after the detecting edge.
        i_sig = 4'b0000;
        tick();
        idle("fall_ignored");
        i_sig = 4'b0100;
        push(2, 1);
        tick();
        idle("ch2_latency");
        tick();
        pop_check("ch2");
        tick();
        idle("ch2_after");

        // Put last on ch3.
        i_sig = 4'b1100;
        push(3, 1);
        tick();
        tick();
        pop_check("ch3");
        i_sig = 4'b0000;
        tick();
        idle("ch3_after");
        tick();

        // Simultaneous rises on 0,1,3 with last=3.
        i_sig = 4'b1011;
        push(0, 1);
        push(1, 1);
        push(3, 1);
        tick();
        tick();
        pop_check("rr_a0");
        tick();
        pop_check("rr_a1");
        tick();
        pop_check("rr_a3");
        i_sig = 4'b0000;
        tick();
        idle("rr_a_after");
        i_sig = 4'b1001;
        push(0, 1);
        push(3, 1);
        tick();
        tick();
        pop_check("rr_b0");
        tick();
        pop_check("rr_b3");
        tick();
        idle("rr_b_after");

        // Overflow: ch2 holds the stalled slot, ch1 (both) toggles twice.
        set_mode(1, 2'b10);
        i_ready = 1'b0;
        i_sig = 4'b1101;
        push(2, 1);
        tick();
        tick();
        i_sig = 4'b1111;
        push(1, 1);
        tick();
        i_sig = 4'b1101;
        tick();
        chk("ovf_set", int'(o_ovf), 4'b0010);
        tick();
        chk("stall_ch", int'(o_ch), 2);
        chk("stall_valid", int'(o_valid), 1);
        i_ready = 1'b1;
        pop_check("ovf_ch2");
        tick();
        pop_check("ovf_ch1");
        tick();
        idle("ovf_after");
        chk("ovf_sticky", int'(o_ovf), 4'b0010);
        i_ovf_clr = 1'b1;
        tick();
        i_ovf_clr = 1'b0;
        chk("ovf_clr", int'(o_ovf), 0);

        // Fall on ch0 while its pending event is granted: re-pends, no overflow.
        set_mode(0, 2'b01);
        i_ready = 1'b0;
        i_sig = 4'b1001;
        tick();
        i_sig = 4'b1101;
        push(2, 1);
        tick();
        tick();
        i_sig = 4'b1100;
        push(0, 0);
        tick();
        i_sig = 4'b1101;
        tick();
        i_sig = 4'b1100;
        i_ready = 1'b1;
        push(0, 0);
        pop_check("regrant_ch2");
        tick();
        pop_check("regrant_first");
        tick();
        pop_check("regrant_second");
        tick();
        idle("regrant_after");
        chk("regrant_ovf", int'(o_ovf), 0);

        // Mode 11 on ch3: toggling never produces an event.
        set_mode(3, 2'b11);
        for (int i = 0; i < 4; i++) begin
            i_sig[3] = ~i_sig[3];
            tick();
            idle("off_toggle");
        end

        // Reset while an event is presented and another is pending.
        set_mode(3, 2'b00);
        i_ready = 1'b0;
        i_sig = 4'b1000;
        tick();
        i_sig = 4'b1100;
        tick();
        i_sig = 4'b1110;
        tick();
        chk("pre_rst_valid", int'(o_valid), 1);
        reset = 1'b1;
        #1;
        chk("async_rst_valid", int'(o_valid), 0);
        tick();
        reset = 1'b0;
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            idle("post_rst_idle");
        end
        chk("post_rst_ovf", int'(o_ovf), 0);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
